// File: rtl/broadcast_n.sv
// broadcast_n: N-way valid/ready/eot stream fork behind a small input FIFO.
// Define BROADCAST_N_STALL_CNT_EN to add per-channel saturating stall counters.
module broadcast_n #(
    parameter int W_DATA      = 18,
    parameter int W_EOT       = 2,
    parameter int N_OUT       = 3,
    parameter int DEPTH       = 4,
    parameter int W_FRAME_CNT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic [W_DATA-1:0]        din_data,
    input  logic [W_EOT-1:0]         din_eot,
    output logic [N_OUT-1:0]         dout_valid,
    input  logic [N_OUT-1:0]         dout_ready,
    output logic [N_OUT*W_DATA-1:0]  dout_data,
    output logic [N_OUT*W_EOT-1:0]   dout_eot,
    input  logic [N_OUT-1:0]         out_en,
    output logic [W_FRAME_CNT-1:0]   frame_cnt,
    output logic                     busy
`ifdef BROADCAST_N_STALL_CNT_EN
    ,
    output logic [N_OUT*16-1:0]      stall_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        FRAME
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [W_DATA+W_EOT-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_nxt;
    logic [N_OUT-1:0]        done;
    logic [N_OUT-1:0]        active_mask;
    logic [N_OUT-1:0]        accept;
    logic [W_DATA-1:0]       head_data;
    logic [W_EOT-1:0]        head_eot;
    logic                    push;
    logic                    pop;
    logic                    head_valid;
    logic                    head_eof;
    logic                    in_frame;
    logic                    load_mask;

    assign push       = din_valid & din_ready;
    assign head_valid = (count != '0);
    assign {head_data, head_eot} = mem[rd_ptr];
    assign head_eof   = &head_eot;

    assign dout_valid = {N_OUT{head_valid}} & active_mask & ~done;
    assign dout_data  = {N_OUT{head_data}};
    assign dout_eot   = {N_OUT{head_eot}};
    assign accept     = dout_valid & dout_ready;

    // A beat retires once every active channel has taken it, now or earlier.
    assign pop        = head_valid & (&(done | accept | ~active_mask));
    assign load_mask  = (~in_frame & ~pop) | (pop & head_eof);
    assign busy       = head_valid | in_frame;

    always_comb begin
        count_nxt = count;
        unique case (1'b1)
            push & ~pop: count_nxt = count + 1'b1;
            pop & ~push: count_nxt = count - 1'b1;
            default:     count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {din_data, din_eot};
        end
    end

    // Ready is registered from the next count, so a full FIFO stays
    // not-ready for the cycle in which it pops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            din_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_nxt;
            din_ready <= (count_nxt < FULL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done        <= '0;
            active_mask <= '1;
            frame_cnt   <= '0;
        end else begin
            if (pop) begin
                done <= '0;
            end else begin
                done <= done | accept;
            end
            if (load_mask) begin
                active_mask <= out_en;
            end
            if (pop & head_eof) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (pop & ~head_eof) state_nxt = FRAME;
            FRAME: if (pop & head_eof)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_frame = (state == FRAME);
    end

`ifdef BROADCAST_N_STALL_CNT_EN
    logic stall_clr;

    assign stall_clr = pop & ~in_frame;

    for (genvar i = 0; i < N_OUT; i++) begin : g_stall
        logic [15:0] cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
            end else if (stall_clr) begin
                cnt <= '0;
            end else if (dout_valid[i] & ~dout_ready[i] & ~&cnt) begin
                cnt <= cnt + 16'd1;
            end
        end

        assign stall_cnt[i*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_broadcast_n.sv
// tb_broadcast_n: table vectors, directed corner sequences and a random
// run checked against a beat-list reference model of the fork.
module tb_broadcast_n;

  localparam int W_DATA = 18;
  localparam int W_EOT  = 2;
  localparam int N      = 3;
  localparam int DEPTH  = 4;
  localparam int WF     = 16;

  logic              clk;
  logic              rst;
  logic              din_valid;
  logic              din_ready;
  logic [W_DATA-1:0] din_data;
  logic [W_EOT-1:0]  din_eot;
  logic [N-1:0]      dout_valid;
  logic [N-1:0]      dout_ready;
  logic [N*W_DATA-1:0] dout_data;
  logic [N*W_EOT-1:0]  dout_eot;
  logic [N-1:0]      out_en;
  logic [WF-1:0]     frame_cnt;
  logic              busy;
`ifdef BROADCAST_N_STALL_CNT_EN
  logic [N*16-1:0]   stall_cnt;
`endif

  broadcast_n #(
    .W_DATA(W_DATA), .W_EOT(W_EOT), .N_OUT(N),
    .DEPTH(DEPTH), .W_FRAME_CNT(WF)
  ) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_data(din_data), .din_eot(din_eot),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_data(dout_data), .dout_eot(dout_eot),
    .out_en(out_en), .frame_cnt(frame_cnt), .busy(busy)
`ifdef BROADCAST_N_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: every pushed beat, with the mask it is meant for
  logic [W_DATA-1:0] b_data [$];
  logic [W_EOT-1:0]  b_eot  [$];
  logic [N-1:0]      b_mask [$];
  int                retired;
  int                nxt [N];
  int                frames;
  int                st [N];
  logic [N-1:0]      plan_mask;

  int cyc;
  int st_ch, st_lo, st_hi;
  int mid_at;
  logic [N-1:0] en_mid;

  typedef struct {
    logic              v;
    logic [W_DATA-1:0] d;
    logic [W_EOT-1:0]  e;
    logic [N-1:0]      rdy;
    logic [N-1:0]      en;
    logic [N-1:0]      x_valid;
    logic [W_DATA-1:0] x_data;
    logic              x_rdy;
    logic              x_busy;
    int                x_fcnt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    b_data.delete();
    b_eot.delete();
    b_mask.delete();
    retired = 0;
    frames  = 0;
    for (int i = 0; i < N; i++) begin
      nxt[i] = 0;
      st[i]  = 0;
    end
  endtask

  function automatic bit m_in_frame();
    return (retired > 0) && (b_eot[retired-1] != 2'b11);
  endfunction

  function automatic int m_occ();
    return b_data.size() - retired;
  endfunction

  // compare this cycle, then advance the model to the next edge
  task automatic sample();
    int occ;
    bit ev [N];
    bit all_done;
    bit fr;
    logic [N-1:0] hm;
    occ = m_occ();
    fr  = m_in_frame();
    hm  = (occ > 0) ? b_mask[retired] : '0;
    chk("din_ready", din_ready, occ < DEPTH);
    chk("busy", busy, (occ != 0) || fr);
    chk("frame_cnt", frame_cnt, frames % 65536);
    for (int i = 0; i < N; i++) begin
      ev[i] = hm[i] && (nxt[i] <= retired);
      chk($sformatf("valid%0d", i), dout_valid[i], ev[i]);
      if (ev[i]) begin
        chk($sformatf("data%0d", i),
            dout_data[i*W_DATA +: W_DATA], b_data[retired]);
        chk($sformatf("eot%0d", i),
            dout_eot[i*W_EOT +: W_EOT], b_eot[retired]);
      end
`ifdef BROADCAST_N_STALL_CNT_EN
      chk($sformatf("stall%0d", i), stall_cnt[i*16 +: 16], st[i]);
      if (ev[i] && !dout_ready[i] && st[i] < 65535) st[i]++;
`endif
    end
    for (int i = 0; i < N; i++) begin
      if (ev[i] && dout_ready[i]) nxt[i] = retired + 1;
    end
    if (occ > 0) begin
      all_done = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (hm[i] && nxt[i] <= retired) all_done = 1'b0;
      end
      if (all_done) begin
        if (!fr) begin
          for (int i = 0; i < N; i++) st[i] = 0;
        end
        if (b_eot[retired] == 2'b11) frames++;
        retired++;
      end
    end
    if (din_valid && din_ready) begin
      b_data.push_back(din_data);
      b_eot.push_back(din_eot);
      b_mask.push_back(plan_mask);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready();
    dout_ready = '1;
    if (cyc >= st_lo && cyc < st_hi) dout_ready[st_ch] = 1'b0;
  endtask

  task automatic run_frame(input int n, input int base, input logic [N-1:0] plan);
    int k;
    k = 0;
    cyc = 0;
    plan_mask = plan;
    while (k < n && cyc < 300) begin
      din_valid = 1'b1;
      din_data  = W_DATA'(base + k);
      din_eot   = (k == n - 1) ? 2'b11 : 2'b00;
      set_ready();
      if (cyc == mid_at) out_en = en_mid;
      if (din_ready) k++;
      tick();
      cyc++;
    end
    din_valid = 1'b0;
    if (k < n) begin
      errors++;
      $display("FAIL push_timeout: pushed %0d, expected %0d", k, n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    din_valid = 1'b0;
    while (m_occ() != 0 && n < 300) begin
      set_ready();
      tick();
      cyc++;
      n++;
    end
    if (m_occ() != 0) begin
      errors++;
      $display("FAIL drain_timeout: occupancy %0d, expected 0", m_occ());
    end
    dout_ready = '1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b0;
    din_valid = 1'b0;
    din_data = '0;
    din_eot = '0;
    dout_ready = '1;
    out_en = '1;
    plan_mask = '1;
    st_ch = 0; st_lo = 0; st_hi = 0;
    mid_at = -1; en_mid = '1;
    cyc = 0;
    model_reset();

    for (int c = 0; c < 10; c++) begin
      tbl[c].v       = (c < 8);
      tbl[c].d       = W_DATA'(c + 1);
      tbl[c].e       = (c == 7) ? 2'b11 : 2'b00;
      tbl[c].rdy     = '1;
      tbl[c].en      = '1;
      tbl[c].x_valid = (c >= 1 && c <= 8) ? 3'b111 : 3'b000;
      tbl[c].x_data  = W_DATA'(c);
      tbl[c].x_rdy   = 1'b1;
      tbl[c].x_busy  = (c >= 1 && c <= 8);
      tbl[c].x_fcnt  = (c == 9) ? 1 : 0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_din_ready", din_ready, 1);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 8-beat frame, all ready
    for (int c = 0; c < 10; c++) begin
      din_valid  = tbl[c].v;
      din_data   = tbl[c].d;
      din_eot    = tbl[c].e;
      dout_ready = tbl[c].rdy;
      out_en     = tbl[c].en;
      @(negedge clk);
      chk("tbl_din_ready", din_ready, tbl[c].x_rdy);
      chk("tbl_busy", busy, tbl[c].x_busy);
      chk("tbl_frame_cnt", frame_cnt, tbl[c].x_fcnt);
      chk("tbl_valid", dout_valid, tbl[c].x_valid);
      if (tbl[c].x_valid != 0) begin
        for (int i = 0; i < N; i++) begin
          chk("tbl_data", dout_data[i*W_DATA +: W_DATA], tbl[c].x_data);
        end
      end
      sample();
      @(posedge clk);
      #1;
    end

    // channel 1 slow for 5 cycles mid-frame
    st_ch = 1; st_lo = 2; st_hi = 7;
    run_frame(8, 100, 3'b111);
    drain();
    st_hi = 0;

    // out_en changes mid-frame, second frame excludes channel 1
    en_mid = 3'b101; mid_at = 3;
    run_frame(6, 300, 3'b111);
    mid_at = -1;
    run_frame(5, 400, 3'b101);
    drain();
    out_en = 3'b111;
    idle(2);

    // all channels masked: beats discarded, frame still counted
    out_en = 3'b000;
    idle(2);
    run_frame(4, 500, 3'b000);
    drain();
    out_en = 3'b111;
    idle(2);

    // random traffic under random masks
    for (int s = 0; s < 6; s++) begin
      out_en = N'($urandom_range(0, 7));
      plan_mask = out_en;
      idle(2);
      for (int c = 0; c < 150; c++) begin
        din_valid = ($urandom % 4) != 0;
        din_data  = W_DATA'($urandom);
        din_eot   = ($urandom % 6 == 0) ? 2'b11 : W_EOT'($urandom_range(0, 2));
        for (int i = 0; i < N; i++) dout_ready[i] = ($urandom % 4) != 0;
        tick();
      end
      din_valid = 1'b0;
      run_frame(1, 1000 + s, out_en);
      drain();
    end
    out_en = 3'b111;
    idle(2);

    // reset with three beats held in the FIFO
    plan_mask = 3'b111;
    dout_ready = '0;
    for (int k = 0; k < 3; k++) begin
      din_valid = 1'b1;
      din_data  = W_DATA'(700 + k);
      din_eot   = 2'b00;
      tick();
    end
    din_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_dout_valid", dout_valid, 0);
    chk("mid_rst_din_ready", din_ready, 1);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    model_reset();
    tick();
    rst = 1'b1;
    dout_ready = '1;
    run_frame(5, 800, 3'b111);
    drain();

`ifdef BROADCAST_N_STALL_CNT_EN
    st_ch = 2; st_lo = 2; st_hi = 9;
    run_frame(4, 900, 3'b111);
    drain();
    st_hi = 0;
    chk("stall_cnt0", stall_cnt[0 +: 16], 0);
    chk("stall_cnt1", stall_cnt[16 +: 16], 0);
    chk("stall_cnt2", stall_cnt[32 +: 16], 7);
    run_frame(2, 950, 3'b111);
    drain();
    chk("stall_clr2", stall_cnt[32 +: 16], 0);
`endif

    chk("final_frame_cnt", frame_cnt, frames % 65536);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/broadcast_n.md
Name: broadcast_n

Overview:
N-way stream fork with end-of-transfer (eot) framing, the generalised successor of the 2-output integral-image broadcast.
Fans one valid/ready/eot stream out to N_OUT consumers, e.g. window buffers, stddev units and extra classifier lanes.
An input FIFO decouples the upstream ready from all downstream readies. Each consumer takes every beat at its own pace, and consumers can be masked per frame.

Parameters:
W_DATA, 18, payload width
W_EOT, 2, eot width; all-ones = end of frame
N_OUT, 3, output channel count (>=1)
DEPTH, 4, input FIFO depth (power of 2, >=2)
W_FRAME_CNT, 16, completed-frame counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
din_valid  in  1  input beat valid
din_ready  out  1  input ready
din_data  in  W_DATA  input payload
din_eot  in  W_EOT  input eot
dout_valid  out  N_OUT  per-channel valid
dout_ready  in  N_OUT  per-channel ready
dout_data  out  N_OUT*W_DATA  channel i at bits [i*W_DATA +: W_DATA]
dout_eot  out  N_OUT*W_EOT  channel i at bits [i*W_EOT +: W_EOT]
out_en  in  N_OUT  requested channel enable mask
frame_cnt  out  W_FRAME_CNT  completed frames, wraps
busy  out  1  FIFO non-empty or frame in progress

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty, so din_ready=1 and dout_valid=0.
  - done mask=0, active_mask=all ones, in_frame=0, frame_cnt=0, busy=0.
- FIFO:
  - Push when din_valid & din_ready.
  - din_ready = (count<DEPTH), registered. It never depends on dout_ready.
  - A pushed beat is visible on the dout ports the next cycle.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Head offer:
  - dout_valid[i] = head_valid & active_mask[i] & ~done[i].
  - All channels carry the same head data/eot. Data/eot are held stable while valid.
- Per-channel accept: dout_valid[i] & dout_ready[i] sets done[i].
- Retire (pop):
  - Pop when head_valid & &(done | accept | ~active_mask).
  - On pop, done clears to 0 in the same edge.
  - Throughput is 1 beat/cycle when all active readies are high.
- Frame tracking:
  - A popped beat sets in_frame=1.
  - A popped beat with eot==all ones clears in_frame and increments frame_cnt (wraps modulo 2^W_FRAME_CNT).
- active_mask:
  - Reloaded from out_en on the cycle in_frame==0 and no pop occurs, so it is constant for a whole frame.
  - It is also reloaded on the end-of-frame pop edge.
  - Changing out_en mid-frame has no effect until the frame ends.
- active_mask==0: head beats are discarded, one per cycle, and frames are still counted.
- Slow consumer: a channel with ready=0 stalls retirement. Other channels that already accepted keep done=1 and show valid=0, so there is no duplicate delivery.
- FIFO full: din_ready=0 until a pop. A full FIFO with a simultaneous pop still shows din_ready=0 that cycle.
- busy = (count!=0) | in_frame.
- Reset mid-frame: partial frame dropped, frame_cnt not incremented.

Optional Feature:
- Macro BROADCAST_N_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt (N_OUT*16). Channel i is at bits [i*16 +: 16].
  - A channel counts a cycle when dout_valid[i] & ~dout_ready[i].
  - Counters saturate at 16'hFFFF. Reset to 0, and cleared on the first pop of each frame (in_frame 0->1).
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- N_OUT=3, all readies=1, out_en=3'b111, 8-beat frame data 1..8, last eot=2'b11 -> each channel receives 1..8 in order with no gaps; frame_cnt=1; busy=0 two cycles after the last push.
- Channel 1 ready=0 for 5 cycles mid-frame -> channels 0/2 see each beat exactly once; FIFO fills to 4 and din_ready=0; after release all channels receive the complete sequence and no beat is duplicated.
- out_en changed from 3'b111 to 3'b101 during frame 1 -> frame 1 still delivered to channel 1; frame 2 dout_valid[1]=0 throughout; frame_cnt=2.
- out_en=3'b000, 4-beat frame -> all beats discarded at 1/cycle; frame_cnt increments to 1; no dout_valid asserted.
- rst pulsed low mid-frame with FIFO count=3 -> immediately dout_valid=0, din_ready=1, frame_cnt=0; a subsequent full frame is delivered correctly.
- With BROADCAST_N_STALL_CNT_EN, channel 2 held stalled 7 cycles -> stall_cnt[2]=7, others 0; cleared to 0 on the next frame's first pop.
